// File: rtl/bus_defs_pkg.sv
// Shared definitions for the data-bus router: FSM encoding, default address map
// and default timeout.
package bus_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int DEF_N_SLAVES       = 6;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  localparam int CH_RAM      = 0;
  localparam int CH_FLASH    = 1;
  localparam int CH_UART     = 2;
  localparam int CH_TIMER    = 3;
  localparam int CH_GRAPHICS = 4;
  localparam int CH_ETHERNET = 5;

  localparam logic [31:0] RAM_BASE      = 32'h8000_0000;
  localparam logic [31:0] RAM_MASK      = 32'hFF80_0000;
  localparam logic [31:0] FLASH_BASE    = 32'h9000_0000;
  localparam logic [31:0] FLASH_MASK    = 32'hFF00_0000;
  localparam logic [31:0] UART_BASE     = 32'hA000_0000;
  localparam logic [31:0] UART_MASK     = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_BASE    = 32'hA000_1000;
  localparam logic [31:0] TIMER_MASK    = 32'hFFFF_F000;
  localparam logic [31:0] GRAPHICS_BASE = 32'hB000_0000;
  localparam logic [31:0] GRAPHICS_MASK = 32'hFF00_0000;
  localparam logic [31:0] ETHERNET_BASE = 32'hC000_0000;
  localparam logic [31:0] ETHERNET_MASK = 32'hFFFF_0000;

  // Builds the packed per-channel base or mask table indexed by channel number.
  function automatic logic [DEF_N_SLAVES-1:0][DEF_ADDR_WIDTH-1:0] default_map(input logic want_mask);
    logic [DEF_N_SLAVES-1:0][DEF_ADDR_WIDTH-1:0] m;
    m              = '0;
    m[CH_RAM]      = want_mask ? RAM_MASK      : RAM_BASE;
    m[CH_FLASH]    = want_mask ? FLASH_MASK    : FLASH_BASE;
    m[CH_UART]     = want_mask ? UART_MASK     : UART_BASE;
    m[CH_TIMER]    = want_mask ? TIMER_MASK    : TIMER_BASE;
    m[CH_GRAPHICS] = want_mask ? GRAPHICS_MASK : GRAPHICS_BASE;
    m[CH_ETHERNET] = want_mask ? ETHERNET_MASK : ETHERNET_BASE;
    return m;
  endfunction

  localparam logic [DEF_N_SLAVES-1:0][DEF_ADDR_WIDTH-1:0] DEF_SLV_BASE = default_map(1'b0);
  localparam logic [DEF_N_SLAVES-1:0][DEF_ADDR_WIDTH-1:0] DEF_SLV_MASK = default_map(1'b1);

endpackage

// File: rtl/data_bus_router_if.sv
// CPU-side and slave-side signal bundle of the data-bus router.
// slave = router view, master = CPU plus slave-device view.
interface data_bus_router_if #(
  parameter int N_SLAVES   = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]                cpu_address;
  logic [DATA_WIDTH-1:0]                cpu_data_wr;
  logic [MASK_W-1:0]                    cpu_mask;
  logic                                 cpu_read;
  logic                                 cpu_write;
  logic [DATA_WIDTH-1:0]                cpu_data_rd;
  logic [DATA_WIDTH-1:0]                cpu_data_rd_2;
  logic                                 cpu_stall;
  logic                                 cpu_error;

  logic [N_SLAVES-1:0][ADDR_WIDTH-1:0]  slv_address;
  logic [N_SLAVES-1:0][DATA_WIDTH-1:0]  slv_data_wr;
  logic [N_SLAVES-1:0][MASK_W-1:0]      slv_mask;
  logic [N_SLAVES-1:0]                  slv_read;
  logic [N_SLAVES-1:0]                  slv_write;
  logic [N_SLAVES-1:0][DATA_WIDTH-1:0]  slv_data_rd;
  logic [N_SLAVES-1:0]                  slv_stall;

  logic [15:0]                          err_count;

  modport slave (
    input  cpu_address, cpu_data_wr, cpu_mask, cpu_read, cpu_write,
    input  slv_data_rd, slv_stall,
    output cpu_data_rd, cpu_data_rd_2, cpu_stall, cpu_error,
    output slv_address, slv_data_wr, slv_mask, slv_read, slv_write,
    output err_count
  );

  modport master (
    output cpu_address, cpu_data_wr, cpu_mask, cpu_read, cpu_write,
    output slv_data_rd, slv_stall,
    input  cpu_data_rd, cpu_data_rd_2, cpu_stall, cpu_error,
    input  slv_address, slv_data_wr, slv_mask, slv_read, slv_write,
    input  err_count
  );

endinterface

// File: rtl/bus_addr_decoder.sv
// Combinational prefix-match address decoder; the lowest matching channel wins.
module bus_addr_decoder #(
  parameter int N_SLAVES   = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = 3,
  parameter logic [N_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [N_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [N_SLAVES-1:0]   o_sel_onehot,
  output logic [IDX_W-1:0]      o_sel_idx,
  output logic                  o_hit
);

  always_comb begin
    o_sel_onehot = '0;
    o_sel_idx    = '0;
    o_hit        = 1'b0;
    // Walk downwards so the lowest matching index is written last.
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((i_address & SLV_MASK[i]) == SLV_BASE[i]) begin
        o_sel_onehot    = '0;
        o_sel_onehot[i] = 1'b1;
        o_sel_idx       = IDX_W'(i);
        o_hit           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_bus_router.sv
// Registered CPU-to-slave data-bus router with per-channel stall enable,
// bus timeout, error responses and a saturating error counter.
//
// state     | meaning
// ST_IDLE   | waiting for cpu_read/cpu_write; request latched here
// ST_ACCESS | strobe on selected channel until slave completes or times out
// ST_DONE   | one-cycle response: data/error presented, stall released
module data_bus_router
  import bus_defs_pkg::*;
#(
  parameter int N_SLAVES   = DEF_N_SLAVES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [N_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter logic [N_SLAVES-1:0] SLV_STALL_EN = '1,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  data_bus_router_if.slave bus
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_req;
  logic [N_SLAVES-1:0]   w_dec_onehot;
  logic [IDX_W-1:0]      w_dec_idx;
  logic                  w_dec_hit;

  logic [N_SLAVES-1:0]   r_sel_onehot;
  logic [IDX_W-1:0]      r_sel_idx;
  logic                  r_is_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_W-1:0]     r_wmask;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_error;
  logic [15:0]           r_err_count;

  logic                  w_sel_stall;
  logic                  w_timeout;
  logic                  w_done_load;
  logic                  w_done_err;
  logic [DATA_WIDTH-1:0] w_done_data;

  assign w_req = bus.cpu_read | bus.cpu_write;

  bus_addr_decoder #(
    .N_SLAVES   (N_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decoder (
    .i_address    (bus.cpu_address),
    .o_sel_onehot (w_dec_onehot),
    .o_sel_idx    (w_dec_idx),
    .o_hit        (w_dec_hit)
  );

  // A channel with stall disabled is treated as never stalling.
  assign w_sel_stall = bus.slv_stall[r_sel_idx] & SLV_STALL_EN[r_sel_idx];
  assign w_timeout   = w_sel_stall && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_done_load = 1'b0;
    w_done_err  = 1'b0;
    w_done_data = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_dec_hit) begin
            w_state_nxt = ST_ACCESS;
          end else begin
            w_state_nxt = ST_DONE;
            w_done_load = 1'b1;
            w_done_err  = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (!w_sel_stall) begin
          w_state_nxt = ST_DONE;
          w_done_load = 1'b1;
          w_done_data = r_is_write ? '0 : bus.slv_data_rd[r_sel_idx];
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_done_load = 1'b1;
          w_done_err  = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_onehot <= '0;
      r_sel_idx    <= '0;
      r_is_write   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_error      <= 1'b0;
      r_err_count  <= '0;
    end else begin
      if (r_state == ST_IDLE && w_req) begin
        r_sel_onehot <= w_dec_onehot;
        r_sel_idx    <= w_dec_idx;
        r_is_write   <= bus.cpu_write;
        r_addr       <= bus.cpu_address;
        r_wdata      <= bus.cpu_data_wr;
        r_wmask      <= bus.cpu_mask;
      end
      if (r_state == ST_ACCESS && w_state_nxt == ST_ACCESS) r_cnt <= r_cnt + 1'b1;
      else                                                  r_cnt <= '0;
      if (w_done_load) begin
        r_rdata <= w_done_data;
        r_error <= w_done_err;
      end
      if (w_done_load && w_done_err && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign bus.cpu_stall     = (r_state == ST_IDLE && w_req) || (r_state == ST_ACCESS);
  assign bus.cpu_data_rd   = r_rdata;
  assign bus.cpu_data_rd_2 = '0;
  assign bus.cpu_error     = r_error;
  assign bus.err_count     = r_err_count;
  assign bus.slv_read      = (r_state == ST_ACCESS && !r_is_write) ? r_sel_onehot : '0;
  assign bus.slv_write     = (r_state == ST_ACCESS &&  r_is_write) ? r_sel_onehot : '0;

  always_comb begin
    bus.slv_address = '0;
    bus.slv_data_wr = '0;
    bus.slv_mask    = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      bus.slv_address[i] = r_addr & ~SLV_MASK[i];
      bus.slv_data_wr[i] = r_wdata;
      bus.slv_mask[i]    = r_wmask;
    end
  end

endmodule

// File: tb/tb_data_bus_router.sv
// Directed self-checking bench for data_bus_router with a small overlapping map,
// channel 1 stall-disabled and an 8-cycle timeout.
module tb_data_bus_router;

  localparam int NS  = 6;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam logic [NS-1:0][AW-1:0] TB_BASE = {32'h8000_0000, 32'hB000_0000, 32'hA000_1000,
                                               32'hA000_0000, 32'h9000_0000, 32'h8000_0000};
  localparam logic [NS-1:0][AW-1:0] TB_MASK = {32'hF000_0000, 32'hFF00_0000, 32'hFFFF_F000,
                                               32'hFFFF_F000, 32'hFF00_0000, 32'hFF80_0000};
  localparam logic [NS-1:0] TB_STALL_EN = 6'b111101;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  int          m_nstall;
  int          m_nstrobe;
  logic [5:0]  m_seen_r;
  logic [5:0]  m_seen_w;
  logic [5:0]  m_done_strb;
  logic        m_stable;
  logic        m_err;
  logic [31:0] m_rdata;
  logic [31:0] m_a0;
  logic [31:0] m_d0;
  logic [3:0]  m_m0;

  data_bus_router_if #(.N_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_bus_router #(
    .N_SLAVES       (NS),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .SLV_BASE       (TB_BASE),
    .SLV_MASK       (TB_MASK),
    .SLV_STALL_EN   (TB_STALL_EN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.cpu_address = '0;
    bus.cpu_data_wr = '0;
    bus.cpu_mask    = '0;
    bus.cpu_read    = 1'b0;
    bus.cpu_write   = 1'b0;
    bus.slv_stall   = '0;
    for (int i = 0; i < NS; i++) bus.slv_data_rd[i] = 32'hC0DE_0000 + 32'(i);
  endtask

  // Drives one access and records what the CPU and the selected slave observed.
  task automatic run_access(input logic [31:0] addr, input logic rd, input logic wr,
                            input logic [31:0] wdata, input logic [3:0] wmask,
                            input int ch, input int stall_n);
    int acc;
    int guard;
    acc = 0;
    guard = 0;
    m_nstall = 0; m_nstrobe = 0; m_seen_r = '0; m_seen_w = '0; m_stable = 1'b1;
    m_a0 = '0; m_d0 = '0; m_m0 = '0;
    @(negedge clk);
    bus.cpu_address = addr;
    bus.cpu_data_wr = wdata;
    bus.cpu_mask    = wmask;
    bus.cpu_read    = rd;
    bus.cpu_write   = wr;
    bus.slv_stall   = '0;
    #1;
    while (bus.cpu_stall && guard < 100) begin
      m_nstall++;
      if ((bus.slv_read | bus.slv_write) != 6'b0) begin
        if (acc == 0) begin
          m_a0 = bus.slv_address[ch];
          m_d0 = bus.slv_data_wr[ch];
          m_m0 = bus.slv_mask[ch];
        end else if (bus.slv_address[ch] !== m_a0 || bus.slv_data_wr[ch] !== m_d0 ||
                     bus.slv_mask[ch] !== m_m0) begin
          m_stable = 1'b0;
        end
        m_seen_r = m_seen_r | bus.slv_read;
        m_seen_w = m_seen_w | bus.slv_write;
        acc++;
        m_nstrobe++;
      end
      @(negedge clk);
      guard++;
      bus.slv_stall = (acc < stall_n) ? (6'b000001 << ch) : 6'b0;
      #1;
    end
    if (guard >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_access_bound: cpu_stall still 1 after %0d cycles, required 0", guard);
    end
    m_rdata     = bus.cpu_data_rd;
    m_err       = bus.cpu_error;
    m_done_strb = bus.slv_read | bus.slv_write;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.slv_stall = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.cpu_stall !== 1'b0) begin n_errors++; $display("FAIL reset cpu_stall: got %0b, expected 0", bus.cpu_stall); end
    n_checks++;
    if ((bus.slv_read | bus.slv_write) !== 6'b0) begin n_errors++; $display("FAIL reset strobes: got %b, expected 000000", bus.slv_read | bus.slv_write); end
    n_checks++;
    if (bus.cpu_data_rd !== 32'h0) begin n_errors++; $display("FAIL reset cpu_data_rd: got %h, expected 0", bus.cpu_data_rd); end
    n_checks++;
    if (bus.cpu_error !== 1'b0) begin n_errors++; $display("FAIL reset cpu_error: got %0b, expected 0", bus.cpu_error); end
    n_checks++;
    if (bus.err_count !== 16'h0) begin n_errors++; $display("FAIL reset err_count: got %h, expected 0", bus.err_count); end
    n_checks++;
    if (bus.cpu_data_rd_2 !== 32'h0) begin n_errors++; $display("FAIL reset cpu_data_rd_2: got %h, expected 0", bus.cpu_data_rd_2); end
  endtask

  task automatic test_stall_write();
    run_access(32'hA000_1020, 1'b0, 1'b1, 32'h1234_5678, 4'b0011, 3, 4);
    n_checks++;
    if (m_nstrobe != 5) begin n_errors++; $display("FAIL stall_write strobe_cycles: got %0d, expected 5", m_nstrobe); end
    n_checks++;
    if (m_nstall != 6) begin n_errors++; $display("FAIL stall_write stall_cycles: got %0d, expected 6", m_nstall); end
    n_checks++;
    if (m_seen_w !== 6'b001000 || m_seen_r !== 6'b0) begin n_errors++; $display("FAIL stall_write strobes: got w=%b r=%b, expected w=001000 r=000000", m_seen_w, m_seen_r); end
    n_checks++;
    if (m_stable !== 1'b1) begin n_errors++; $display("FAIL stall_write stable: got %0b, expected 1", m_stable); end
    n_checks++;
    if (m_d0 !== 32'h1234_5678 || m_m0 !== 4'b0011 || m_a0 !== 32'h20) begin n_errors++; $display("FAIL stall_write payload: got d=%h m=%b a=%h, expected d=12345678 m=0011 a=00000020", m_d0, m_m0, m_a0); end
    n_checks++;
    if (m_err !== 1'b0 || m_rdata !== 32'h0) begin n_errors++; $display("FAIL stall_write response: got err=%0b data=%h, expected err=0 data=0", m_err, m_rdata); end
  endtask

  task automatic test_read_nostall();
    bus.slv_data_rd[0] = 32'hDEAD_BEEF;
    run_access(32'h8000_0010, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0);
    n_checks++;
    if (m_nstall != 2) begin n_errors++; $display("FAIL read_nostall stall_cycles: got %0d, expected 2", m_nstall); end
    n_checks++;
    if (m_seen_r !== 6'b000001 || m_seen_w !== 6'b0) begin n_errors++; $display("FAIL read_nostall strobes: got r=%b w=%b, expected r=000001 w=000000", m_seen_r, m_seen_w); end
    n_checks++;
    if (m_a0 !== 32'h10) begin n_errors++; $display("FAIL read_nostall slv_address: got %h, expected 00000010", m_a0); end
    n_checks++;
    if (m_rdata !== 32'hDEAD_BEEF || m_err !== 1'b0) begin n_errors++; $display("FAIL read_nostall response: got data=%h err=%0b, expected data=deadbeef err=0", m_rdata, m_err); end
    n_checks++;
    if (m_done_strb !== 6'b0) begin n_errors++; $display("FAIL read_nostall done_strobes: got %b, expected 000000", m_done_strb); end
  endtask

  task automatic test_overlap();
    bus.slv_data_rd[5] = 32'h5555_AAAA;
    run_access(32'h8100_0004, 1'b1, 1'b0, 32'h0, 4'h0, 5, 0);
    n_checks++;
    if (m_seen_r !== 6'b100000) begin n_errors++; $display("FAIL overlap strobes: got %b, expected 100000", m_seen_r); end
    n_checks++;
    if (m_a0 !== 32'h0100_0004) begin n_errors++; $display("FAIL overlap slv_address: got %h, expected 01000004", m_a0); end
    n_checks++;
    if (m_rdata !== 32'h5555_AAAA) begin n_errors++; $display("FAIL overlap data: got %h, expected 5555aaaa", m_rdata); end
  endtask

  task automatic test_unmapped();
    run_access(32'h0000_0004, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0);
    n_checks++;
    if (m_nstall != 1 || m_nstrobe != 0) begin n_errors++; $display("FAIL unmapped timing: got stall=%0d strobe=%0d, expected stall=1 strobe=0", m_nstall, m_nstrobe); end
    n_checks++;
    if (m_err !== 1'b1 || m_rdata !== 32'h0) begin n_errors++; $display("FAIL unmapped response: got err=%0b data=%h, expected err=1 data=0", m_err, m_rdata); end
    n_checks++;
    if (bus.err_count !== 16'd1) begin n_errors++; $display("FAIL unmapped err_count: got %0d, expected 1", bus.err_count); end
  endtask

  task automatic test_timeout();
    run_access(32'hB000_0000, 1'b1, 1'b0, 32'h0, 4'h0, 4, 1000);
    n_checks++;
    if (m_nstrobe != TMO || m_nstall != TMO + 1) begin n_errors++; $display("FAIL timeout timing: got strobe=%0d stall=%0d, expected strobe=8 stall=9", m_nstrobe, m_nstall); end
    n_checks++;
    if (m_err !== 1'b1 || m_rdata !== 32'h0) begin n_errors++; $display("FAIL timeout response: got err=%0b data=%h, expected err=1 data=0", m_err, m_rdata); end
    n_checks++;
    if (m_done_strb !== 6'b0) begin n_errors++; $display("FAIL timeout done_strobes: got %b, expected 000000", m_done_strb); end
    n_checks++;
    if (bus.err_count !== 16'd2) begin n_errors++; $display("FAIL timeout err_count: got %0d, expected 2", bus.err_count); end
  endtask

  task automatic test_dual_strobe();
    bus.slv_data_rd[2] = 32'h7777_7777;
    run_access(32'hA000_0044, 1'b1, 1'b1, 32'hCAFE_F00D, 4'hF, 2, 0);
    n_checks++;
    if (m_seen_w !== 6'b000100 || m_seen_r !== 6'b0) begin n_errors++; $display("FAIL dual strobes: got w=%b r=%b, expected w=000100 r=000000", m_seen_w, m_seen_r); end
    n_checks++;
    if (m_rdata !== 32'h0 || m_d0 !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL dual data: got rd=%h wr=%h, expected rd=0 wr=cafef00d", m_rdata, m_d0); end
  endtask

  task automatic test_err_saturate();
    @(negedge clk);
    force dut.r_err_count = 16'hFFFD;
    @(negedge clk);
    release dut.r_err_count;
    run_access(32'h0000_0008, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0);
    n_checks++;
    if (bus.err_count !== 16'hFFFE) begin n_errors++; $display("FAIL saturate step: got %h, expected fffe", bus.err_count); end
    run_access(32'h0000_0008, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0);
    run_access(32'h0000_0008, 1'b1, 1'b0, 32'h0, 4'h0, 0, 0);
    n_checks++;
    if (bus.err_count !== 16'hFFFF) begin n_errors++; $display("FAIL saturate hold: got %h, expected ffff", bus.err_count); end
  endtask

  task automatic test_stall_disable();
    bus.slv_data_rd[1] = 32'h0BAD_F00D;
    run_access(32'h9000_0040, 1'b1, 1'b0, 32'h0, 4'h0, 1, 1000);
    n_checks++;
    if (m_nstall != 2) begin n_errors++; $display("FAIL stall_disable stall_cycles: got %0d, expected 2", m_nstall); end
    n_checks++;
    if (m_rdata !== 32'h0BAD_F00D || m_err !== 1'b0) begin n_errors++; $display("FAIL stall_disable response: got data=%h err=%0b, expected data=0badf00d err=0", m_rdata, m_err); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    bus.cpu_address = 32'hA000_0008;
    bus.cpu_read    = 1'b1;
    bus.slv_stall   = 6'b000100;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.slv_read !== 6'b000100) begin n_errors++; $display("FAIL midreset pre strobe: got %b, expected 000100", bus.slv_read); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ((bus.slv_read | bus.slv_write) !== 6'b0 || bus.cpu_stall !== 1'b1) begin n_errors++; $display("FAIL midreset idle: got strobes=%b stall=%0b, expected strobes=000000 stall=1", bus.slv_read | bus.slv_write, bus.cpu_stall); end
    n_checks++;
    if (bus.cpu_data_rd !== 32'h0 || bus.cpu_error !== 1'b0 || bus.err_count !== 16'h0) begin n_errors++; $display("FAIL midreset outputs: got data=%h err=%0b cnt=%h, expected 0 0 0", bus.cpu_data_rd, bus.cpu_error, bus.err_count); end
    n_checks++;
    if (bus.slv_address[2] !== 32'h0) begin n_errors++; $display("FAIL midreset slv_address: got %h, expected 0", bus.slv_address[2]); end
    bus.cpu_read  = 1'b0;
    bus.slv_stall = '0;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.cpu_stall !== 1'b0 || (bus.slv_read | bus.slv_write) !== 6'b0) begin n_errors++; $display("FAIL midreset settle: got stall=%0b strobes=%b, expected 0 000000", bus.cpu_stall, bus.slv_read | bus.slv_write); end
  endtask

  initial begin
    test_reset();
    test_stall_write();
    test_read_nostall();
    test_overlap();
    test_unmapped();
    test_timeout();
    test_dual_strobe();
    test_err_saturate();
    test_stall_disable();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_bus_router.md
# data_bus_router

Parametrised, registered successor to the single-cycle data-bus decoder. It sits between the CPU data port and N memory-mapped slaves (RAM, flash, UART, timer, graphics, ethernet, …). It decodes each access against a parameter address map and drives exactly one slave from registered request state. It also adds what the combinational decoder lacks: a per-channel stall-enable, a bus timeout, error responses for unmapped or hung accesses, and a saturating error counter.

## Interface
- `N_SLAVES`, 6: number of slave channels.
- `ADDR_WIDTH`, 32: CPU and slave address width.
- `DATA_WIDTH`, 32: data width. The mask width is `DATA_WIDTH/8`.
- `SLV_BASE`, per-channel `ADDR_WIDTH` array: prefix value of each channel.
- `SLV_MASK`, per-channel `ADDR_WIDTH` array: prefix bits compared, 1 = compared.
- `SLV_STALL_EN`, `N_SLAVES` bits, all 1: channel honours `slv_stall`. When 0, the channel always completes in one access cycle.
- `TIMEOUT_CYCLES`, 256: maximum number of ACCESS cycles before an error response. Must be ≥ 2.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cpu_address`, in, `ADDR_WIDTH`: CPU access address.
- `cpu_data_wr`, in, `DATA_WIDTH`: write data.
- `cpu_mask`, in, `DATA_WIDTH/8`: byte enables.
- `cpu_read` / `cpu_write`, in, 1 each: access strobes. They are held stable while `cpu_stall` = 1.
- `cpu_data_rd`, out, `DATA_WIDTH`: read data, valid in the DONE cycle.
- `cpu_data_rd_2`, out, `DATA_WIDTH`: tied to 0. One word per access.
- `cpu_stall`, out, 1: CPU must hold its request while this is 1.
- `cpu_error`, out, 1: the current response is an error (unmapped address or timeout).
- `slv_address`, out, `N_SLAVES`×`ADDR_WIDTH`: offset = address & ~`SLV_MASK[i]`, registered.
- `slv_data_wr`, out, `N_SLAVES`×`DATA_WIDTH`: registered write data, broadcast to all channels.
- `slv_mask`, out, `N_SLAVES`×`DATA_WIDTH/8`: registered byte enables, broadcast to all channels.
- `slv_read` / `slv_write`, out, `N_SLAVES` each: one-hot strobes.
- `slv_data_rd`, in, `N_SLAVES`×`DATA_WIDTH`: slave read data.
- `slv_stall`, in, `N_SLAVES`: slave busy.
- `err_count`, out, 16: saturating count of error responses.

## Operation
FSM states are IDLE, ACCESS and DONE.
- **IDLE**
  - When `cpu_read|cpu_write`: latch address, data, mask, direction and decoded channel; go to ACCESS.
  - If no channel matches, latch an error and go straight to DONE instead.
- **Decode**
  - Channel i matches when (`cpu_address` & `SLV_MASK[i]`) == `SLV_BASE[i]`.
  - If several channels match, the lowest index wins.
- **Direction**
  - If `cpu_read` and `cpu_write` are both 1, the access is a write.
- **ACCESS**
  - The selected channel's `slv_read` or `slv_write` is 1; all other strobes are 0.
  - Completion is when `slv_stall[sel]` = 0 or `SLV_STALL_EN[sel]` = 0. On completion, capture `slv_data_rd[sel]` (reads; writes capture 0) and go to DONE.
  - Otherwise increment the timeout counter. When the counter reaches `TIMEOUT_CYCLES-1` with the slave still stalling, go to DONE with error and data 0.
- **DONE**
  - All strobes are 0; `cpu_stall` = 0.
  - `cpu_data_rd` = captured data; `cpu_error` = latched flag.
  - Next state is IDLE unconditionally.
- **Error counting**
  - `err_count` increments on entry to DONE with error and saturates at 0xFFFF.

## Timing
- **Reset** (`rst_n` = 0 at a rising edge): state = IDLE, all `slv_read`/`slv_write` = 0, `cpu_data_rd` = 0, `cpu_error` = 0, `err_count` = 0, timeout counter = 0.
  - Registered address, data and mask reset to 0.
  - Reset mid-ACCESS aborts the access; the strobes drop in the following cycle.
- **`cpu_stall`** = (state==IDLE & (`cpu_read|cpu_write`)) | state==ACCESS. It is combinational, so the stall is visible in the request cycle.
- **Latency**
  - Mapped access to a non-stalling slave: stall for 2 cycles, data in cycle 3.
  - Each slave stall cycle adds 1.
  - Unmapped access: stall for 1 cycle, error in cycle 2.
  - Timeout: the error response comes `TIMEOUT_CYCLES` cycles after ACCESS entry.
- **Strobe width**: the strobe stays high for every ACCESS cycle. The slave sees a stable address, data and mask throughout.
- **After DONE**: the IDLE cycle samples a new request. Back-to-back accesses therefore have a period of 3 cycles minimum.
- **Outside DONE**: `cpu_data_rd` and `cpu_error` hold their last value.

## Structure
- Package `bus_defs_pkg`:
  - FSM state enum;
  - default address-map constants (RAM, FLASH, UART, TIMER, GRAPHICS, ETHERNET base/mask);
  - channel index constants;
  - `TIMEOUT_CYCLES` default.
- Sub-module `bus_addr_decoder`: combinational prefix match with priority select. Outputs one-hot select, binary index and a `hit` flag. It is instantiated once in the router.
- Counter width is $clog2(`TIMEOUT_CYCLES`).

## Test plan
- **Non-stalling read**: read 0x8000_0010 to RAM channel 0 (base 0x8000_0000, mask 0xFF80_0000), `slv_data_rd[0]` = 0xDEAD_BEEF, no stall → stall for 2 cycles, `cpu_data_rd` = 0xDEAD_BEEF in cycle 3, `slv_address[0]` = 0x10, `cpu_error` = 0.
- **Stalling write**: write 0x1234_5678 with mask 0b0011 to channel 3, `slv_stall[3]` high for 4 cycles → `slv_write[3]` high for 5 cycles with constant data and mask, then `cpu_stall` drops for one cycle.
- **Unmapped address**: read 0x0000_0004 → no slave strobe asserted, 1 stall cycle, then `cpu_error` = 1, data 0, `err_count` = 1.
- **Timeout**: `TIMEOUT_CYCLES` = 8, slave held stalled → error response after 8 ACCESS cycles, strobe deasserted in DONE. 0xFFFF+2 errors leave `err_count` = 0xFFFF.
- **Overlap, stall-disable and dual strobes**:
  - Overlapping map: the lowest index is selected.
  - `SLV_STALL_EN[1]` = 0 with `slv_stall[1]` = 1: completes in 2 stall cycles.
  - `cpu_read` and `cpu_write` both 1: write only.
- **Reset mid-ACCESS**: `rst_n` low for one edge while `slv_read[2]` is high → next cycle all strobes are 0, state is IDLE, outputs are at their reset values.
